// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N-to-1 channel multiplexer with a direct-select
// mode and a round-robin auto-scan mode over a channel mask. Every output word
// is tagged with its channel index (out_ch) and with a start-of-sweep marker
// (frame), so the block can serialise channels onto a single lane.
module mux_nto1_scan #(
  parameter int N_IN  = 16,
  parameter int WIDTH = 1,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    en,
  input  logic [N_IN-1:0]         ch_mask,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  output logic                    frame,
  output logic                    sel_err
);

  // Scan position following the channel just emitted. Wraps at N_IN rather
  // than at 2**SEL_W, so the pointer never names a channel that does not exist.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] c);
    if (int'(c) == N_IN - 1)
      return '0;
    else
      return c + 1'b1;
  endfunction

  logic [WIDTH-1:0] chan [N_IN];
  logic             mode_q;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] start;
  logic             hi_found;
  logic [SEL_W-1:0] hi_idx;
  logic             any_found;
  logic [SEL_W-1:0] any_idx;
  logic [SEL_W-1:0] scan_ch;
  logic             sel_ok;

  // Unpack the flat input bus into per-channel words.
  for (genvar k = 0; k < N_IN; k++) begin : g_chan
    assign chan[k] = in[k*WIDTH +: WIDTH];
  end

  // Rotating priority search. The lowest enabled channel at or above the
  // start point wins; if there is none, the sweep wraps to the lowest
  // enabled channel overall (necessarily below the start point).
  always_comb begin
    start     = mode_q ? ptr : '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_found = 1'b0;
    any_idx   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        any_found = 1'b1;
        any_idx   = SEL_W'(k);
        if (k >= int'(start)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(k);
        end
      end
    end
    scan_ch = hi_found ? hi_idx : any_idx;
    sel_ok  = (int'(sel) < N_IN);
  end

  // Output register: direct select or one scan step per enabled cycle.
  // The status strobes are single-cycle and drop whenever nothing new is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      frame     <= 1'b0;
      sel_err   <= 1'b0;
      ptr       <= '0;
      mode_q    <= 1'b0;
    end else begin
      mode_q    <= mode;
      out_valid <= 1'b0;
      frame     <= 1'b0;
      sel_err   <= 1'b0;
      if (en) begin
        if (!mode) begin
          out_ch <= sel;
          if (sel_ok) begin
            out       <= chan[sel];
            out_valid <= 1'b1;
          end else begin
            out     <= '0;
            sel_err <= 1'b1;
          end
        end else if (any_found) begin
          out       <= chan[scan_ch];
          out_ch    <= scan_ch;
          out_valid <= 1'b1;
          frame     <= !mode_q || (scan_ch <= out_ch);
          ptr       <= next_ptr(scan_ch);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: a 16x1 and a 12x4 instance driven one at a time.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] in16;
  logic [3:0]  sel16;
  logic        mode16, en16;
  logic [15:0] mask16;
  logic [0:0]  out16;
  logic [3:0]  ch16;
  logic        vld16, frm16, err16;

  logic [47:0] in12;
  logic [3:0]  sel12;
  logic        mode12, en12;
  logic [11:0] mask12;
  logic [3:0]  out12;
  logic [3:0]  ch12;
  logic        vld12, frm12, err12;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          which;
    string       name;
    logic [3:0]  out;
    logic [3:0]  ch;
    logic        valid;
    logic        frame;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0] sel;
    logic       exp_out;
  } dvec_t;

  dvec_t dtab[4];

  logic [0:0] lo16;
  logic [3:0] lc16;

  mux_nto1_scan #(.N_IN(16), .WIDTH(1)) dut16 (
    .clk(clk), .rst(rst), .in(in16), .sel(sel16), .mode(mode16), .en(en16),
    .ch_mask(mask16), .out(out16), .out_ch(ch16), .out_valid(vld16),
    .frame(frm16), .sel_err(err16)
  );

  mux_nto1_scan #(.N_IN(12), .WIDTH(4)) dut12 (
    .clk(clk), .rst(rst), .in(in12), .sel(sel12), .mode(mode12), .en(en12),
    .ch_mask(mask12), .out(out12), .out_ch(ch12), .out_valid(vld12),
    .frame(frm12), .sel_err(err12)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic step(input int which, input logic [3:0] s, input logic m, input logic e,
                      input logic [15:0] msk, input logic [3:0] eo, input logic [3:0] ec,
                      input logic ev, input logic ef, input logic ee, input string nm);
    exp_t x;
    if (which == 16) begin
      sel16 = s; mode16 = m; en16 = e; mask16 = msk; en12 = 1'b0;
    end else begin
      sel12 = s; mode12 = m; en12 = e; mask12 = msk[11:0]; en16 = 1'b0;
    end
    x.which = which; x.name = nm; x.out = eo; x.ch = ec;
    x.valid = ev; x.frame = ef; x.err = ee;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard"}, 32'(0), 32'(1));
    end else begin
      x = sb.pop_front();
      if (x.which == 16) begin
        chk({x.name, " out"},   32'(out16), 32'(x.out));
        chk({x.name, " ch"},    32'(ch16),  32'(x.ch));
        chk({x.name, " valid"}, 32'(vld16), 32'(x.valid));
        chk({x.name, " frame"}, 32'(frm16), 32'(x.frame));
        chk({x.name, " err"},   32'(err16), 32'(x.err));
      end else begin
        chk({x.name, " out"},   32'(out12), 32'(x.out));
        chk({x.name, " ch"},    32'(ch12),  32'(x.ch));
        chk({x.name, " valid"}, 32'(vld12), 32'(x.valid));
        chk({x.name, " frame"}, 32'(frm12), 32'(x.frame));
        chk({x.name, " err"},   32'(err12), 32'(x.err));
      end
    end
  endtask

  // Scan word on the 16-channel instance: data comes from in16 at channel c.
  task automatic scan16(input logic [3:0] c, input logic f, input logic [15:0] msk, input string nm);
    logic [0:0] d;
    d = in16[c];
    step(16, 4'd0, 1'b1, 1'b1, msk, 4'(d), c, 1'b1, f, 1'b0, nm);
    lo16 = d;
    lc16 = c;
  endtask

  // No new word on the 16-channel instance: data and channel keep their last values.
  task automatic hold16(input logic m, input logic e, input logic [15:0] msk, input string nm);
    step(16, 4'd0, m, e, msk, 4'(lo16), lc16, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic scan12(input logic [3:0] c, input logic f, input logic [11:0] msk, input string nm);
    logic [3:0] d;
    d = in12[int'(c)*4 +: 4];
    step(12, 4'd0, 1'b1, 1'b1, {4'd0, msk}, d, c, 1'b1, f, 1'b0, nm);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " out16"}, 32'(out16), 32'(0));
    chk({nm, " ch16"},  32'(ch16),  32'(0));
    chk({nm, " vld16"}, 32'(vld16), 32'(0));
    chk({nm, " frm16"}, 32'(frm16), 32'(0));
    chk({nm, " err16"}, 32'(err16), 32'(0));
    chk({nm, " out12"}, 32'(out12), 32'(0));
    chk({nm, " ch12"},  32'(ch12),  32'(0));
    chk({nm, " vld12"}, 32'(vld12), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    in16 = 16'h0; sel16 = '0; mode16 = 1'b0; en16 = 1'b0; mask16 = '0;
    in12 = 48'h0; sel12 = '0; mode12 = 1'b0; en12 = 1'b0; mask12 = '0;
    lo16 = '0; lc16 = '0;

    dtab[0] = '{sel: 4'd0,  exp_out: 1'b0};
    dtab[1] = '{sel: 4'd1,  exp_out: 1'b1};
    dtab[2] = '{sel: 4'd6,  exp_out: 1'b0};
    dtab[3] = '{sel: 4'd12, exp_out: 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Direct select on a fixed pattern
    in16 = 16'h3f0a;
    for (int i = 0; i < 4; i++) begin
      step(16, dtab[i].sel, 1'b0, 1'b1, 16'h0000, 4'(dtab[i].exp_out), dtab[i].sel,
           1'b1, 1'b0, 1'b0, $sformatf("direct%0d", i));
      lo16 = dtab[i].exp_out;
      lc16 = dtab[i].sel;
    end

    // Full-mask sweep, fresh data every word
    for (int i = 0; i < 17; i++) begin
      in16 = 16'($urandom);
      scan16(4'(i % 16), (i % 16) == 0, 16'hffff, $sformatf("full%0d", i));
    end

    // Sparse mask, empty mask, enable gap
    in16 = 16'ha5c3;
    hold16(1'b0, 1'b0, 16'hffff, "leave_scan");
    scan16(4'd0,  1'b1, 16'h8421, "sparse0");
    scan16(4'd5,  1'b0, 16'h8421, "sparse5");
    scan16(4'd10, 1'b0, 16'h8421, "sparse10");
    scan16(4'd15, 1'b0, 16'h8421, "sparse15");
    scan16(4'd0,  1'b1, 16'h8421, "sparse0b");
    scan16(4'd5,  1'b0, 16'h8421, "sparse5b");
    hold16(1'b1, 1'b1, 16'h0000, "nomask_a");
    hold16(1'b1, 1'b1, 16'h0000, "nomask_b");
    for (int i = 0; i < 3; i++)
      hold16(1'b1, 1'b0, 16'h8421, $sformatf("en_off%0d", i));
    scan16(4'd10, 1'b0, 16'h8421, "resume10");
    scan16(4'd15, 1'b0, 16'h8421, "resume15");

    // 12-channel, 4-bit instance: bad select, wrap, single channel
    in12 = {16'($urandom), 32'($urandom)};
    step(12, 4'd13, 1'b0, 1'b1, 16'h0, 4'd0, 4'd13, 1'b0, 1'b0, 1'b1, "sel_err13");
    step(12, 4'd11, 1'b0, 1'b1, 16'h0, in12[47:44], 4'd11, 1'b1, 1'b0, 1'b0, "direct11");
    scan12(4'd8,  1'b1, 12'h100, "n12_first8");
    scan12(4'd9,  1'b0, 12'hfff, "n12_9");
    scan12(4'd10, 1'b0, 12'hfff, "n12_10");
    scan12(4'd11, 1'b0, 12'hfff, "n12_11");
    scan12(4'd0,  1'b1, 12'hfff, "n12_wrap0");
    scan12(4'd4,  1'b0, 12'h010, "single_a");
    scan12(4'd4,  1'b1, 12'h010, "single_b");
    scan12(4'd4,  1'b1, 12'h010, "single_c");

    // Asynchronous reset in the middle of a sweep
    in16 = 16'h5a96;
    hold16(1'b0, 1'b0, 16'hffff, "pre_rst");
    for (int i = 0; i < 8; i++)
      scan16(4'(i), i == 0, 16'hffff, $sformatf("pre_rst%0d", i));
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    lo16 = '0;
    lc16 = '0;
    scan16(4'd0, 1'b1, 16'hffff, "post_rst0");
    scan16(4'd1, 1'b0, 16'hffff, "post_rst1");
    scan16(4'd2, 1'b0, 16'hffff, "post_rst2");
    scan16(4'd3, 1'b0, 16'hffff, "post_rst3");

    // Scan -> direct -> scan restarts the sweep at 0
    step(16, 4'd9, 1'b0, 1'b1, 16'hffff, 4'(in16[9]), 4'd9, 1'b1, 1'b0, 1'b0, "mode_dir9");
    step(16, 4'd2, 1'b0, 1'b1, 16'hffff, 4'(in16[2]), 4'd2, 1'b1, 1'b0, 1'b0, "mode_dir2");
    scan16(4'd0, 1'b1, 16'hffff, "rescan0");
    scan16(4'd1, 1'b0, 16'hffff, "rescan1");

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
